// File: rtl/multidiv_iter_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multidiv_iter_counter_pkg
// Description : Shared multdiv definitions: state encodings, step opcodes and
//               default iteration constants for the multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package multidiv_iter_counter_pkg;

    localparam int unsigned c_md_iter_width = 6;
    localparam int unsigned c_md_mul_iters  = 32;
    localparam int unsigned c_md_div_iters  = 32;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = c_st_idle,
        S_RUN  = c_st_run,
        S_DONE = c_st_done
    } state_e;

    typedef enum logic [1:0] {
        UD_HOLD = 2'd0,
        UD_INC  = 2'd1,
        UD_DEC  = 2'd2
    } ud_op_e;

endpackage
`default_nettype wire

// File: rtl/multidiv_iter_counter_updown_reg.sv
`default_nettype none
// ============================================================================
// Module      : updown_reg
// Description : WIDTH-bit register with async active-low clear, synchronous
//               load and increment/decrement/hold select (load has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module updown_reg
    import multidiv_iter_counter_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  ud_op_e           i_op,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else begin
            case (i_op)
                UD_INC:  r_q <= r_q + 1'b1;
                UD_DEC:  r_q <= r_q - 1'b1;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/multidiv_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : multidiv_iter_counter
// Description : Programmable up/down iteration sequencer with start/busy/done
//               handshake for the multiply/divide datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module multidiv_iter_counter
    import multidiv_iter_counter_pkg::*;
#(
    parameter int WIDTH = c_md_iter_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    state_e           r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_final;

    logic             w_accept;
    logic             w_n_zero;
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_val;
    ud_op_e           w_op;

    assign w_accept = (r_state != S_RUN) && start && !abort;
    assign w_n_zero = (load_val == '0);

    // Final index is latched at start so last is a pure register decode.
    assign last = (r_state == S_RUN) && (count == r_final);
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_comb begin
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_op     = UD_HOLD;
        if (abort) begin
            w_ld = 1'b1;
        end else if (w_accept) begin
            w_ld     = 1'b1;
            w_ld_val = (dir && !w_n_zero) ? (load_val - 1'b1) : '0;
        end else if ((r_state == S_RUN) && en && !last) begin
            w_op = r_dir ? UD_DEC : UD_INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_dir   <= 1'b0;
            r_final <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (en && last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        if (w_n_zero) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                            r_dir   <= dir;
                            r_final <= dir ? '0 : (load_val - 1'b1);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    updown_reg #(
        .WIDTH(WIDTH)
    ) u_count (
        .clk       (clk),
        .rst_n     (rst),
        .i_load    (w_ld),
        .i_load_val(w_ld_val),
        .i_op      (w_op),
        .o_q       (count)
    );

endmodule
`default_nettype wire
